// File: rtl/sram_fifo_ctrl.sv
// FIFO controller that keeps its words in an external single-port synchronous SRAM.
// Pops take priority over pushes; read data comes back two cycles after an accepted pop.
module sram_fifo_ctrl #(
  parameter int ADDRESS_BITS = 5,
  parameter int DATA_WIDTH   = 8,
  parameter int NUM_REG      = 32
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    push,
  input  logic [DATA_WIDTH-1:0]   push_data,
  output logic                    push_ready,
  input  logic                    pop,
  output logic                    pop_ready,
  output logic [DATA_WIDTH-1:0]   dout,
  output logic                    dout_valid,
  output logic                    full,
  output logic                    empty,
  output logic [ADDRESS_BITS:0]   count,
  output logic                    mem_cs,
  output logic                    mem_we,
  output logic                    mem_rd,
  output logic [ADDRESS_BITS-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_wr_data,
  input  logic [DATA_WIDTH-1:0]   mem_rd_data
);

  typedef enum logic {IDLE, RD_WAIT} state_t;

  localparam logic [ADDRESS_BITS-1:0] LAST_IDX = ADDRESS_BITS'(NUM_REG - 1);
  localparam logic [ADDRESS_BITS:0]   DEPTH    = (ADDRESS_BITS + 1)'(NUM_REG);
  localparam logic [ADDRESS_BITS-1:0] PTR_ONE  = ADDRESS_BITS'(1);
  localparam logic [ADDRESS_BITS:0]   CNT_ONE  = (ADDRESS_BITS + 1)'(1);

  state_t                  state;
  state_t                  state_next;
  logic [ADDRESS_BITS-1:0] wr_ptr;
  logic [ADDRESS_BITS-1:0] rd_ptr;
  logic                    pop_acc;
  logic                    push_acc;

  // Depth need not be a power of two, so wrap explicitly at the last slot.
  function automatic logic [ADDRESS_BITS-1:0] next_ptr(input logic [ADDRESS_BITS-1:0] ptr);
    return (ptr == LAST_IDX) ? '0 : ptr + PTR_ONE;
  endfunction

  assign empty      = (count == '0);
  assign full       = (count == DEPTH);
  assign pop_ready  = (state == IDLE) && !empty;
  assign pop_acc    = pop && pop_ready;
  assign push_ready = !full && !pop_acc;
  assign push_acc   = push && push_ready;

  always_comb begin
    state_next  = IDLE;
    mem_cs      = 1'b0;
    mem_we      = 1'b0;
    mem_rd      = 1'b1;
    mem_addr    = wr_ptr;
    mem_wr_data = push_data;
    if (pop_acc) begin
      state_next = RD_WAIT;
      mem_cs     = 1'b1;
      mem_rd     = 1'b0;
      mem_addr   = rd_ptr;
    end else if (push_acc) begin
      mem_cs = 1'b1;
      mem_we = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      state <= state_next;
      if (pop_acc) begin
        rd_ptr <= next_ptr(rd_ptr);
        count  <= count - CNT_ONE;
      end else if (push_acc) begin
        wr_ptr <= next_ptr(wr_ptr);
        count  <= count + CNT_ONE;
      end
    end
  end

  // The SRAM word is on mem_rd_data throughout RD_WAIT; capture it as that cycle ends.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dout       <= '0;
      dout_valid <= 1'b0;
    end else begin
      dout_valid <= (state == RD_WAIT);
      if (state == RD_WAIT) begin
        dout <= mem_rd_data;
      end
    end
  end

endmodule

// File: tb/tb_sram_fifo_ctrl.sv
// Randomized and directed bench for sram_fifo_ctrl against a queue-based FIFO model,
// plus a small NUM_REG=5 instance to exercise non-power-of-two pointer wrap.
module tb_sram_fifo_ctrl;

  localparam int AW = 5;
  localparam int DW = 8;
  localparam int NR = 32;

  logic          clk = 1'b0;
  logic          reset_n = 1'b1;
  logic          push = 1'b0;
  logic          pop = 1'b0;
  logic [DW-1:0] push_data = '0;
  logic          push_ready, pop_ready, dout_valid, full, empty;
  logic [DW-1:0] dout;
  logic [AW:0]   count;
  logic          mem_cs, mem_we, mem_rd;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wr_data;
  logic [DW-1:0] mem_rd_data = '0;
  logic [DW-1:0] mem [0:(1<<AW)-1];

  logic          push_5 = 1'b0;
  logic          pop_5 = 1'b0;
  logic [DW-1:0] push_data_5 = '0;
  logic          push_ready_5, pop_ready_5, dout_valid_5, full_5, empty_5;
  logic [DW-1:0] dout_5;
  logic [3:0]    count_5;
  logic          mem_cs_5, mem_we_5, mem_rd_5;
  logic [2:0]    mem_addr_5;
  logic [DW-1:0] mem_wr_data_5;
  logic [DW-1:0] mem_rd_data_5 = '0;
  logic [DW-1:0] mem5 [0:7];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sram_fifo_ctrl #(.ADDRESS_BITS(AW), .DATA_WIDTH(DW), .NUM_REG(NR)) u_dut (
    .clk(clk), .reset_n(reset_n), .push(push), .push_data(push_data),
    .push_ready(push_ready), .pop(pop), .pop_ready(pop_ready), .dout(dout),
    .dout_valid(dout_valid), .full(full), .empty(empty), .count(count),
    .mem_cs(mem_cs), .mem_we(mem_we), .mem_rd(mem_rd), .mem_addr(mem_addr),
    .mem_wr_data(mem_wr_data), .mem_rd_data(mem_rd_data)
  );

  sram_fifo_ctrl #(.ADDRESS_BITS(3), .DATA_WIDTH(DW), .NUM_REG(5)) u_dut5 (
    .clk(clk), .reset_n(reset_n), .push(push_5), .push_data(push_data_5),
    .push_ready(push_ready_5), .pop(pop_5), .pop_ready(pop_ready_5), .dout(dout_5),
    .dout_valid(dout_valid_5), .full(full_5), .empty(empty_5), .count(count_5),
    .mem_cs(mem_cs_5), .mem_we(mem_we_5), .mem_rd(mem_rd_5), .mem_addr(mem_addr_5),
    .mem_wr_data(mem_wr_data_5), .mem_rd_data(mem_rd_data_5)
  );

  // Single-port synchronous SRAMs seen by the two controllers.
  always @(posedge clk) begin
    if (mem_cs && mem_we) mem[mem_addr] <= mem_wr_data;
    else if (mem_cs && !mem_rd) mem_rd_data <= mem[mem_addr];
    if (mem_cs_5 && mem_we_5) mem5[mem_addr_5] <= mem_wr_data_5;
    else if (mem_cs_5 && !mem_rd_5) mem_rd_data_5 <= mem5[mem_addr_5];
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference model: contents as a queue, pointers as counts modulo depth,
  // and each accepted pop scheduled to appear on dout two cycles later.
  typedef struct {
    int            due;
    logic [DW-1:0] val;
  } exp_t;

  logic [DW-1:0] model_q[$];
  exp_t          exp_q[$];
  int            wr_idx = 0;
  int            rd_idx = 0;
  int            last_pop_cyc = -10;
  int            cyc = 0;
  logic [DW-1:0] model_dout = '0;
  bit            m_pop_ready, m_pop_acc, m_push_ready, m_push_acc, m_valid;

  always @(negedge clk) begin
    if (!reset_n) begin
      checkOutput("rst_count", 32'(count), 0);
      checkOutput("rst_empty", 32'(empty), 1);
      checkOutput("rst_full", 32'(full), 0);
      checkOutput("rst_dout", 32'(dout), 0);
      checkOutput("rst_dout_valid", 32'(dout_valid), 0);
      checkOutput("rst_pop_ready", 32'(pop_ready), 0);
      model_q.delete();
      exp_q.delete();
      wr_idx = 0;
      rd_idx = 0;
      last_pop_cyc = -10;
      model_dout = '0;
    end else begin
      m_pop_ready  = (last_pop_cyc != cyc - 1) && (model_q.size() != 0);
      m_pop_acc    = pop && m_pop_ready;
      m_push_ready = (model_q.size() < NR) && !m_pop_acc;
      m_push_acc   = push && m_push_ready;
      m_valid      = (exp_q.size() != 0) && (exp_q[0].due == cyc);
      if (m_valid) begin
        model_dout = exp_q[0].val;
        exp_q.delete(0);
      end
      checkOutput("pop_ready", 32'(pop_ready), 32'(m_pop_ready));
      checkOutput("push_ready", 32'(push_ready), 32'(m_push_ready));
      checkOutput("count", 32'(count), model_q.size());
      checkOutput("empty", 32'(empty), 32'(model_q.size() == 0));
      checkOutput("full", 32'(full), 32'(model_q.size() == NR));
      checkOutput("mem_cs", 32'(mem_cs), 32'(m_pop_acc || m_push_acc));
      checkOutput("mem_we", 32'(mem_we), 32'(m_push_acc));
      checkOutput("mem_rd", 32'(mem_rd), 32'(!m_pop_acc));
      checkOutput("mem_addr", 32'(mem_addr), m_pop_acc ? rd_idx : wr_idx);
      checkOutput("mem_wr_data", 32'(mem_wr_data), 32'(push_data));
      checkOutput("we_rd_exclusive", 32'(mem_we && !mem_rd), 0);
      checkOutput("dout_valid", 32'(dout_valid), 32'(m_valid));
      checkOutput("dout", 32'(dout), 32'(model_dout));
      if (m_pop_acc) begin
        exp_q.push_back('{due: cyc + 2, val: model_q.pop_front()});
        rd_idx = (rd_idx + 1) % NR;
        last_pop_cyc = cyc;
      end else if (m_push_acc) begin
        model_q.push_back(push_data);
        wr_idx = (wr_idx + 1) % NR;
      end
    end
    cyc++;
  end

  task automatic applyStimulus(input logic ps, input logic [DW-1:0] d, input logic pp);
    @(posedge clk);
    #1;
    push = ps;
    push_data = d;
    pop = pp;
    @(negedge clk);
  endtask

  task automatic applyStimulus5(input logic ps, input logic [DW-1:0] d, input logic pp);
    @(posedge clk);
    #1;
    push_5 = ps;
    push_data_5 = d;
    pop_5 = pp;
    @(negedge clk);
  endtask

  task automatic doReset();
    @(posedge clk);
    #1;
    reset_n = 1'b0;
    push = 1'b0;
    pop = 1'b0;
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  logic [DW-1:0] vals [0:2];

  initial begin
    vals[0] = 8'h11;
    vals[1] = 8'h22;
    vals[2] = 8'h33;
    #1 reset_n = 1'b0;
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1 reset_n = 1'b1;

    // Three consecutive pushes land at addresses 0,1,2.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, vals[i], 1'b0);
      checkOutput("push3_we", 32'(mem_we), 1);
      checkOutput("push3_addr", 32'(mem_addr), i);
    end
    applyStimulus(1'b0, '0, 1'b0);
    checkOutput("push3_count", 32'(count), 3);
    checkOutput("push3_empty", 32'(empty), 0);

    // Pop held high: accepted every other cycle, data two cycles after acceptance.
    for (int k = 0; k < 6; k++) begin
      applyStimulus(1'b0, '0, 1'b1);
      checkOutput("pop3_ready", 32'(pop_ready), 32'(k % 2 == 0));
      if (k >= 2 && k % 2 == 0) begin
        checkOutput("pop3_valid", 32'(dout_valid), 1);
        checkOutput("pop3_dout", 32'(dout), 32'(vals[k/2-1]));
      end
    end
    applyStimulus(1'b0, '0, 1'b0);
    checkOutput("pop3_last_valid", 32'(dout_valid), 1);
    checkOutput("pop3_last_dout", 32'(dout), 32'h33);
    checkOutput("pop3_empty", 32'(empty), 1);
    applyStimulus(1'b0, '0, 1'b0);
    checkOutput("dout_hold_valid", 32'(dout_valid), 0);
    checkOutput("dout_hold", 32'(dout), 32'h33);

    // Fill, refuse the overflow push, then wrap the write pointer back to 0.
    doReset();
    for (int i = 0; i < NR; i++) begin
      applyStimulus(1'b1, 8'(8'h40 + i), 1'b0);
      checkOutput("fill_full", 32'(full), 0);
    end
    applyStimulus(1'b1, 8'hFF, 1'b0);
    checkOutput("ovf_full", 32'(full), 1);
    checkOutput("ovf_push_ready", 32'(push_ready), 0);
    checkOutput("ovf_cs", 32'(mem_cs), 0);
    checkOutput("ovf_count", 32'(count), 32);
    applyStimulus(1'b0, '0, 1'b1);
    checkOutput("wrap_pop_addr", 32'(mem_addr), 0);
    applyStimulus(1'b1, 8'hEE, 1'b0);
    checkOutput("wrap_push_we", 32'(mem_we), 1);
    checkOutput("wrap_push_addr", 32'(mem_addr), 0);
    applyStimulus(1'b0, '0, 1'b0);
    checkOutput("wrap_count", 32'(count), 32);
    checkOutput("wrap_dout", 32'(dout), 32'h40);

    // Push and pop together at count=1: pop wins, push lands during RD_WAIT.
    doReset();
    applyStimulus(1'b1, 8'hA5, 1'b0);
    applyStimulus(1'b1, 8'h5A, 1'b1);
    checkOutput("both_rd", 32'(mem_rd), 0);
    checkOutput("both_we", 32'(mem_we), 0);
    checkOutput("both_push_ready", 32'(push_ready), 0);
    applyStimulus(1'b1, 8'h5A, 1'b1);
    checkOutput("both_wait_pop_ready", 32'(pop_ready), 0);
    checkOutput("both_wait_we", 32'(mem_we), 1);
    checkOutput("both_wait_addr", 32'(mem_addr), 1);
    applyStimulus(1'b0, '0, 1'b0);
    checkOutput("both_dout", 32'(dout), 32'hA5);
    checkOutput("both_count", 32'(count), 1);

    // Pop at empty is refused; reset during RD_WAIT suppresses the data pulse.
    doReset();
    applyStimulus(1'b0, '0, 1'b1);
    checkOutput("empty_pop_ready", 32'(pop_ready), 0);
    checkOutput("empty_pop_cs", 32'(mem_cs), 0);
    applyStimulus(1'b0, '0, 1'b0);
    applyStimulus(1'b1, 8'h77, 1'b0);
    applyStimulus(1'b0, '0, 1'b1);
    checkOutput("abort_pop_cs", 32'(mem_cs), 1);
    @(posedge clk);
    #1;
    reset_n = 1'b0;
    pop = 1'b0;
    repeat (2) begin
      @(negedge clk);
      checkOutput("abort_valid", 32'(dout_valid), 0);
      checkOutput("abort_count", 32'(count), 0);
    end
    @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);

    // Depth-5 instance: pointers wrap 0..4 and order is preserved.
    for (int i = 0; i < 12; i++) begin
      applyStimulus5(1'b1, 8'(8'h80 + i), 1'b0);
      checkOutput("d5_push_we", 32'(mem_we_5), 1);
      checkOutput("d5_push_addr", 32'(mem_addr_5), i % 5);
      if (i > 0) begin
        checkOutput("d5_valid", 32'(dout_valid_5), 1);
        checkOutput("d5_dout", 32'(dout_5), 32'(8'h80 + i - 1));
      end
      applyStimulus5(1'b0, '0, 1'b1);
      checkOutput("d5_pop_rd", 32'(mem_rd_5), 0);
      checkOutput("d5_pop_addr", 32'(mem_addr_5), i % 5);
      applyStimulus5(1'b0, '0, 1'b0);
    end
    applyStimulus5(1'b0, '0, 1'b0);
    checkOutput("d5_last_dout", 32'(dout_5), 32'h8B);
    checkOutput("d5_empty", 32'(empty_5), 1);

    // Random traffic: push-heavy first to reach full, then pop-heavy to drain.
    for (int i = 0; i < 1200; i++) begin
      if ($urandom_range(0, 299) == 0) doReset();
      if (i < 600)
        applyStimulus($urandom_range(0, 99) < 60, 8'($urandom), $urandom_range(0, 99) < 40);
      else
        applyStimulus($urandom_range(0, 99) < 30, 8'($urandom), $urandom_range(0, 99) < 75);
    end
    applyStimulus(1'b0, '0, 1'b0);
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sram_fifo_ctrl.md
SRAM_FIFO_CTRL -- requirements
Module: sram_fifo_ctrl

Interface
REQ-001 Parameter ADDRESS_BITS, default 5, memory address width.
REQ-002 Parameter DATA_WIDTH, default 8, data word width.
REQ-003 Parameter NUM_REG, default 32, FIFO depth in words, SHALL be <= 2**ADDRESS_BITS.
REQ-004 Ports SHALL be as follows; clock and reset first:
- clk  input  1  sole clock; all state updates on its rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- push  input  1  write request.
- push_data  input  DATA_WIDTH  word to enqueue.
- push_ready  output  1  push is accepted this cycle.
- pop  input  1  read request.
- pop_ready  output  1  pop is accepted this cycle.
- dout  output  DATA_WIDTH  last dequeued word.
- dout_valid  output  1  one-cycle pulse; dout holds a new word.
- full  output  1  count == NUM_REG.
- empty  output  1  count == 0.
- count  output  ADDRESS_BITS+1  words stored.
- mem_cs  output  1  memory chip select.
- mem_we  output  1  memory write enable, active-high.
- mem_rd  output  1  memory read strobe, active-low.
- mem_addr  output  ADDRESS_BITS  memory address.
- mem_wr_data  output  DATA_WIDTH  memory write data.
- mem_rd_data  input  DATA_WIDTH  memory read data; valid the cycle after a read strobe.

Function
REQ-005 The memory SHALL be single-port synchronous: write on a rising edge when cs&we; read on a rising edge when cs&!rd&!we; read data available on mem_rd_data in the following cycle.
REQ-006 FSM states SHALL be IDLE and RD_WAIT.
REQ-007 pop_ready SHALL be (state==IDLE)&&!empty; pop is accepted iff pop&&pop_ready.
REQ-008 push_ready SHALL be !full&&!(pop&&pop_ready); push is accepted iff push&&push_ready.
REQ-009 Simultaneous push and pop in IDLE with !empty: pop wins and push stalls.
REQ-010 Accepted pop: mem_cs=1, mem_we=0, mem_rd=0, mem_addr=rd_ptr, combinational in the same cycle; next state RD_WAIT; rd_ptr advances; count decrements.
REQ-011 Accepted push: mem_cs=1, mem_we=1, mem_rd=1, mem_addr=wr_ptr, mem_wr_data=push_data, combinational; wr_ptr advances; count increments.
REQ-012 With no accepted request, the outputs SHALL be mem_cs=0, mem_we=0, mem_rd=1. mem_addr and mem_wr_data are don't-care; drive wr_ptr and push_data.
REQ-013 RD_WAIT: dout SHALL register mem_rd_data at the rising edge ending the cycle, dout_valid=1 the next cycle, and the state returns to IDLE. Read latency from accepted pop to dout_valid is 2 cycles.
REQ-014 In RD_WAIT, pop SHALL be ignored and push is accepted per REQ-008.
REQ-015 Pointers SHALL wrap from NUM_REG-1 to 0; NUM_REG need not be a power of two.
REQ-016 A push at full and a pop at empty SHALL be refused, with no change to the pointers, count or memory.
REQ-017 count, full and empty SHALL be registered-consistent: they reflect the accepted operations at each edge, and push and pop never both change count in one cycle.
REQ-018 dout SHALL hold its value between dout_valid pulses.

Reset
REQ-019 On reset_n low, without waiting for clk: state=IDLE, wr_ptr=rd_ptr=0, count=0, empty=1, full=0, dout=0, dout_valid=0.
REQ-020 A reset asserted in RD_WAIT SHALL abort the read with no dout_valid pulse; memory contents need not be cleared.

Verification
REQ-021 Reset, then push 0x11,0x22,0x33 on consecutive cycles -> mem_we pulses at addrs 0,1,2; count=3; empty=0.
REQ-022 Pop three times from that state -> dout 0x11,0x22,0x33, each dout_valid 2 cycles after acceptance; pop_ready=0 during RD_WAIT; empty=1 at the end.
REQ-023 Fill 32 words, then push 0xFF -> full=1, push_ready=0, no write; pop, then push -> write at addr 0 (wrap); count=32.
REQ-024 push and pop held high with count=1 -> read at rd_ptr first, push stalls that cycle and is accepted in RD_WAIT; mem_we and !mem_rd are never both active.
REQ-025 Pop at empty -> pop_ready=0, mem_cs=0, no dout_valid; assert reset_n low in RD_WAIT -> dout_valid stays 0, count=0.
REQ-026 NUM_REG=5, 12 push/pop pairs -> pointer sequence 0..4,0..; data order preserved.
